// File: rtl/ir_alu_seq_if.sv
// ---------------------------------------------------------------------------
// ir_alu_seq_if
//   Instruction handshake and retirement bus for ir_alu_seq.
//
//   instr_valid / instr / instr_ready : one instruction per valid&ready edge
//   done / err                        : one-cycle retirement pulses
//   wb_addr / wb_data                 : destination and result of retiring op
//
//   master : instruction producer (fetch/control unit or bench)
//   slave  : ir_alu_seq
// ---------------------------------------------------------------------------
interface ir_alu_seq_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              done;
  logic              err;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, err, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, err, wb_addr, wb_data
  );
endinterface

// File: rtl/ir_alu_seq.sv
// ---------------------------------------------------------------------------
// ir_alu_seq
//   Sequential IR + ALU datapath. Latches one instruction per handshake,
//   decodes it, reads the GPR file, executes, writes back and updates flags.
//
//   Instruction fields: oper_type=[31:27] rdst=[26:22] rsrc1=[21:17]
//                       mode=[16] rsrc2=[15:11] isrc=[15:0]
//
//   Ports:
//     clk        system clock, rising edge
//     sys_rst_n  asynchronous active-low reset
//     bus        ir_alu_seq_if.slave (handshake + retirement signals)
//     flags      {sign, zero, carry, overflow}
//     sgpr       multiply high word
//     dbg_addr   debug GPR read address
//     dbg_data   GPR[dbg_addr], combinational, 0 when out of range
//
//   Build option: define IR_ALU_MUL_EN to enable the iterative shift-add
//   multiplier (opcode 4). Without it opcode 4 retires as illegal.
// ---------------------------------------------------------------------------
module ir_alu_seq #(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 32
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  ir_alu_seq_if.slave       bus,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef IR_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2, MUL = 2'd3} state_t;
  localparam int CNT_W = $clog2(DATA_W);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
`endif

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;

  state_t            state;
  logic [31:0]       ir;
  // Sized to the full 5-bit address space; entries at or above NUM_GPR are
  // never written and stay constant zero.
  logic [DATA_W-1:0] gpr [32];
  logic              carry_q, ovf_q, legal_q;

  wire [4:0]  opc   = ir[31:27];
  wire [4:0]  rdst  = ir[26:22];
  wire [4:0]  rsrc1 = ir[21:17];
  wire        mode  = ir[16];
  wire [4:0]  rsrc2 = ir[15:11];
  wire [15:0] isrc  = ir[15:0];

  logic [DATA_W-1:0] op1, op2, alu_res;
  logic [DATA_W:0]   sum_ext;
  logic              alu_c, alu_v, illegal;

  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path through the case statements can infer a latch.
  always_comb begin
    op1     = (int'(rsrc1) < NUM_GPR) ? gpr[rsrc1] : '0;
    op2     = mode ? DATA_W'(isrc) : ((int'(rsrc2) < NUM_GPR) ? gpr[rsrc2] : '0);
    alu_res = '0;
    sum_ext = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    illegal = (int'(rdst) >= NUM_GPR) || (int'(rsrc1) >= NUM_GPR) ||
              (!mode && (int'(rsrc2) >= NUM_GPR));
    case (opc)
      OP_MOVSGPR: alu_res = sgpr;
      OP_MOV:     alu_res = op2;
      OP_ADD: begin
        sum_ext = {1'b0, op1} + {1'b0, op2};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (op1[DATA_W-1] == op2[DATA_W-1]) && (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
      OP_SUB: begin
        // Bit DATA_W of the extended difference is the unsigned borrow.
        sum_ext = {1'b0, op1} - {1'b0, op2};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (op1[DATA_W-1] != op2[DATA_W-1]) && (alu_res[DATA_W-1] != op1[DATA_W-1]);
      end
`ifndef IR_ALU_MUL_EN
      OP_MUL:  illegal = 1'b1;
`endif
      OP_OR:   alu_res = op1 | op2;
      OP_AND:  alu_res = op1 & op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_XNOR: alu_res = ~(op1 ^ op2);
      OP_NAND: alu_res = ~(op1 & op2);
      OP_NOR:  alu_res = ~(op1 | op2);
      OP_NOT:  alu_res = ~op1;
      default: begin
        // Opcode 4 lands here only in the multiplier build, where the MUL
        // state produces the result instead of the ALU.
        if (opc != OP_MUL) illegal = 1'b1;
      end
    endcase
  end

`ifdef IR_ALU_MUL_EN
  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  logic [2*DATA_W-1:0] prod, prod_next;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W:0]     part;
  logic [CNT_W-1:0]    cnt;
  logic                mul_q;

  always_comb begin
    part      = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {part, prod[DATA_W-1:1]};
  end
`endif

  assign dbg_data = (int'(dbg_addr) < NUM_GPR) ? gpr[dbg_addr] : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      ir              <= '0;
      flags           <= '0;
      sgpr            <= '0;
      carry_q         <= 1'b0;
      ovf_q           <= 1'b0;
      legal_q         <= 1'b0;
      bus.instr_ready <= 1'b1;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.wb_addr     <= '0;
      bus.wb_data     <= '0;
      // NOTE: the register file is deliberately reset; software relies on
      // GPRs reading zero after reset, so this cannot map to a reset-less RAM.
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
`ifdef IR_ALU_MUL_EN
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
      mul_q <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            ir              <= bus.instr;
            bus.instr_ready <= 1'b0;
            state           <= EXEC;
          end
        end
        EXEC: begin
          bus.wb_addr <= rdst;
          carry_q     <= alu_c;
          ovf_q       <= alu_v;
          legal_q     <= !illegal;
`ifdef IR_ALU_MUL_EN
          mul_q       <= !illegal && (opc == OP_MUL);
`endif
          if (illegal) begin
            bus.wb_data <= '0;
            bus.err     <= 1'b1;
            bus.done    <= 1'b1;
            state       <= WB;
`ifdef IR_ALU_MUL_EN
          end else if (opc == OP_MUL) begin
            prod  <= {{DATA_W{1'b0}}, op2};
            mcand <= op1;
            cnt   <= '0;
            state <= MUL;
`endif
          end else begin
            bus.wb_data <= alu_res;
            bus.done    <= 1'b1;
            state       <= WB;
          end
        end
`ifdef IR_ALU_MUL_EN
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            bus.wb_data <= prod_next[DATA_W-1:0];
            bus.done    <= 1'b1;
            state       <= WB;
          end
        end
`endif
        WB: begin
          if (legal_q) begin
            gpr[bus.wb_addr] <= bus.wb_data;
            flags <= {bus.wb_data[DATA_W-1], (bus.wb_data == '0), carry_q, ovf_q};
`ifdef IR_ALU_MUL_EN
            if (mul_q) sgpr <= prod[2*DATA_W-1:DATA_W];
`endif
          end
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_ir_alu_seq
//   Directed bench for ir_alu_seq. A second instance with NUM_GPR=8 receives
//   the same instruction stream so register-range legality can be observed.
// ---------------------------------------------------------------------------
module tb_ir_alu_seq;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        flags, flags8;
  logic [DATA_W-1:0] sgpr, sgpr8, dbg_data, dbg_data8;
  logic [4:0]        dbg_addr = '0, dbg_addr8 = '0;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] last_data;
  logic [4:0]        last_addr;
  logic              last_err, last_err8;

  ir_alu_seq_if #(.DATA_W(DATA_W)) bus ();
  ir_alu_seq_if #(.DATA_W(DATA_W)) bus8 ();

  assign bus8.instr_valid = bus.instr_valid;
  assign bus8.instr       = bus.instr;

  ir_alu_seq #(.DATA_W(DATA_W), .NUM_GPR(32)) dut (
    .clk(clk), .sys_rst_n(rst_n), .bus(bus), .flags(flags), .sgpr(sgpr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  ir_alu_seq #(.DATA_W(DATA_W), .NUM_GPR(8)) dut8 (
    .clk(clk), .sys_rst_n(rst_n), .bus(bus8), .flags(flags8), .sgpr(sgpr8),
    .dbg_addr(dbg_addr8), .dbg_data(dbg_data8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ri(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'b0};
  endfunction

  // Present one instruction, wait for retirement; lat counts negedges after
  // the capture edge, so a non-mul op retires with lat==2 (cycle T+2).
  task automatic issue(input logic [31:0] ins, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.instr_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL retire_timeout instr=%h no done within 200 cycles", ins);
    end
    last_data = bus.wb_data;
    last_addr = bus.wb_addr;
    last_err  = bus.err;
    last_err8 = bus8.err;
  endtask

  task automatic run(input logic [31:0] ins);
    int lat;
    issue(ins, lat);
  endtask

  task automatic peek(input logic [4:0] a, output logic [DATA_W-1:0] v);
    dbg_addr = a;
    #1 v = dbg_data;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] v;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", bus.done, bus.err); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    checks++; if (sgpr !== '0 || bus.wb_data !== '0 || bus.wb_addr !== '0) begin failures++; $display("FAIL reset_regs sgpr=%h wb_data=%h wb_addr=%0d exp=0", sgpr, bus.wb_data, bus.wb_addr); end
    peek(5'd17, v);
    checks++; if (v !== '0) begin failures++; $display("FAIL reset_gpr17 got=%h exp=0", v); end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) run(ri(5'd1, 5'(i), 5'd0, 16'd2));
  endtask

  task automatic test_add();
    int lat;
    logic [DATA_W-1:0] v;
    issue(ri(5'd2, 5'd0, 5'd2, 16'd4), lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (last_data !== 32'd6 || last_addr !== 5'd0 || last_err !== 1'b0) begin failures++; $display("FAIL add_wb data=%h addr=%0d err=%b exp=6/0/0", last_data, last_addr, last_err); end
    @(negedge clk);
    peek(5'd0, v);
    checks++; if (v !== 32'd6) begin failures++; $display("FAIL add_gpr0 got=%h exp=6", v); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL add_flags got=%b exp=0000", flags); end
  endtask

  task automatic test_sub();
    logic [DATA_W-1:0] v;
    run(ri(5'd1, 5'd1, 5'd0, 16'd3));
    run(ri(5'd1, 5'd2, 5'd0, 16'd5));
    run(rr(5'd3, 5'd3, 5'd1, 5'd2));
    checks++; if (last_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_wb got=%h exp=fffffffe", last_data); end
    @(negedge clk);
    peek(5'd3, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_gpr3 got=%h exp=fffffffe", v); end
    checks++; if (flags !== 4'b1010) begin failures++; $display("FAIL sub_flags got=%b exp=1010", flags); end
  endtask

  task automatic test_overflow();
    run(ri(5'd1, 5'd9, 5'd0, 16'h8000));
    for (int i = 0; i < 16; i++) run(rr(5'd2, 5'd9, 5'd9, 5'd9));
    run(ri(5'd3, 5'd9, 5'd9, 16'd1));
    checks++; if (last_data !== 32'h7FFF_FFFF) begin failures++; $display("FAIL ovf_setup got=%h exp=7fffffff", last_data); end
    run(ri(5'd2, 5'd10, 5'd9, 16'd1));
    checks++; if (last_data !== 32'h8000_0000) begin failures++; $display("FAIL ovf_add got=%h exp=80000000", last_data); end
    @(negedge clk);
    checks++; if (flags !== 4'b1001) begin failures++; $display("FAIL ovf_flags got=%b exp=1001", flags); end
    run(ri(5'd5, 5'd11, 5'd9, 16'd0));
    @(negedge clk);
    checks++; if (flags !== 4'b0000 || last_data !== 32'h7FFF_FFFF) begin failures++; $display("FAIL or_clears flags=%b data=%h exp=0000/7fffffff", flags, last_data); end
  endtask

  task automatic test_mul();
    int lat;
    logic [DATA_W-1:0] v;
    run(ri(5'd1, 5'd1, 5'd0, 16'd0));
    run(ri(5'd3, 5'd1, 5'd1, 16'd1));
    issue(ri(5'd4, 5'd4, 5'd1, 16'd2), lat);
`ifdef IR_ALU_MUL_EN
    checks++; if (lat !== 2 + DATA_W) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, 2 + DATA_W); end
    checks++; if (last_err !== 1'b0 || last_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_wb err=%b data=%h exp=0/fffffffe", last_err, last_data); end
    @(negedge clk);
    peek(5'd4, v);
    checks++; if (v !== 32'hFFFF_FFFE || sgpr !== 32'd1) begin failures++; $display("FAIL mul_result gpr4=%h sgpr=%h exp=fffffffe/1", v, sgpr); end
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL mul_flags got=%b exp=1000", flags); end
    run(ri(5'd0, 5'd5, 5'd0, 16'd0));
    @(negedge clk);
    peek(5'd5, v);
    checks++; if (v !== 32'd1) begin failures++; $display("FAIL movsgpr_gpr5 got=%h exp=1", v); end
`else
    checks++; if (lat !== 2) begin failures++; $display("FAIL mul_latency got=%0d exp=2", lat); end
    checks++; if (last_err !== 1'b1 || last_data !== '0) begin failures++; $display("FAIL mul_illegal err=%b data=%h exp=1/0", last_err, last_data); end
    @(negedge clk);
    peek(5'd4, v);
    checks++; if (v !== 32'd2 || sgpr !== '0) begin failures++; $display("FAIL mul_nochange gpr4=%h sgpr=%h exp=2/0", v, sgpr); end
    checks++; if (flags !== 4'b1010) begin failures++; $display("FAIL mul_flags got=%b exp=1010", flags); end
`endif
  endtask

  task automatic test_illegal();
    int lat;
    logic [DATA_W-1:0] v;
    run(ri(5'd1, 5'd7, 5'd0, 16'd0));
    issue(ri(5'd15, 5'd6, 5'd0, 16'd0), lat);
    checks++; if (lat !== 2 || last_err !== 1'b1 || last_data !== '0) begin failures++; $display("FAIL op15_retire lat=%0d err=%b data=%h exp=2/1/0", lat, last_err, last_data); end
    @(negedge clk);
    peek(5'd6, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL op15_gpr6 got=%h exp=2", v); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL op15_flags got=%b exp=0100", flags); end
  endtask

  task automatic test_bad_reg();
    logic [DATA_W-1:0] v;
    run(ri(5'd1, 5'd7, 5'd0, 16'd0));
    run(ri(5'd1, 5'd9, 5'd0, 16'd5));
    checks++; if (last_err8 !== 1'b1 || last_err !== 1'b0) begin failures++; $display("FAIL badreg_err err8=%b err32=%b exp=1/0", last_err8, last_err); end
    @(negedge clk);
    checks++; if (flags8 !== 4'b0100) begin failures++; $display("FAIL badreg_flags got=%b exp=0100", flags8); end
    dbg_addr8 = 5'd9;
    #1 v = dbg_data8;
    checks++; if (v !== '0) begin failures++; $display("FAIL badreg_dbg9 got=%h exp=0", v); end
    dbg_addr8 = 5'd0;
    #1 v = dbg_data8;
    checks++; if (v !== 32'd6) begin failures++; $display("FAIL badreg_gpr0 got=%h exp=6", v); end
  endtask

  task automatic test_back_to_back();
    int n, w;
    logic [DATA_W-1:0] v;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ri(5'd1, 5'd1, 5'd0, 16'd7);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!bus.done && w < 50);
    // Now in WB of the mov: present the add and hold it.
    bus.instr_valid = 1'b1;
    bus.instr       = ri(5'd2, 5'd2, 5'd1, 16'd1);
    checks++; if (bus.instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_wb got=%b exp=0", bus.instr_ready); end
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      if (bus.instr_ready && bus.instr_valid) begin
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        n = k;
        break;
      end
    end
    bus.instr_valid = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_accept_delay got=%0d exp=3", n); end
    checks++; if (bus.wb_data !== 32'd8) begin failures++; $display("FAIL b2b_result got=%h exp=8", bus.wb_data); end
    @(negedge clk);
    peek(5'd2, v);
    checks++; if (v !== 32'd8) begin failures++; $display("FAIL b2b_gpr2 got=%h exp=8", v); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [DATA_W-1:0] v0, v3;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ri(5'd2, 5'd0, 5'd0, 16'd1);
    @(posedge clk);
    #1 begin
      bus.instr_valid = 1'b0;
      rst_n = 1'b0;
    end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_during done=%b ready=%b exp=0/1", bus.done, bus.instr_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.instr_ready); end
    peek(5'd0, v0);
    peek(5'd3, v3);
    checks++; if (v0 !== '0 || v3 !== '0 || flags !== 4'b0000) begin failures++; $display("FAIL rstmid_cleared gpr0=%h gpr3=%h flags=%b exp=0", v0, v3, flags); end
  endtask

  initial begin
    test_reset();
    preload();
    test_add();
    test_sub();
    test_overflow();
    test_mul();
    test_illegal();
    test_bad_reg();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1);
  end
endmodule

// File: doc/ir_alu_seq.md
Name: ir_alu_seq

Overview:
- Sequential successor to the combinational IR+ALU datapath.
- Accepts one 32-bit instruction per valid/ready handshake and latches it into IR. Decodes the same field layout as before, reads a parametrised GPR file, executes the operation over a fixed number of cycles, writes back, and updates condition flags.
- Sits between the future fetch/control unit and the register file; a debug read port exposes GPR contents to benches.

Parameters:
- DATA_W, 32, GPR/SGPR/result width; legal range 16..64.
- NUM_GPR, 32, number of GPRs; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction present on instr.
- instr  input  32  instruction word.
- instr_ready  output  1  block can accept an instruction.
- done  output  1  one-cycle pulse: instruction retired.
- err  output  1  one-cycle pulse, coincident with done: illegal instruction.
- wb_addr  output  5  destination register of the retiring instruction.
- wb_data  output  DATA_W  result of the retiring instruction.
- flags  output  4  {sign, zero, carry, overflow}.
- sgpr  output  DATA_W  special register holding the multiply high word.
- dbg_addr  input  5  debug GPR read address.
- dbg_data  output  DATA_W  GPR[dbg_addr], combinational; 0 if dbg_addr >= NUM_GPR.

Behaviour:
- IR fields: oper_type=[31:27], rdst=[26:22], rsrc1=[21:17], mode=[16], rsrc2=[15:11], isrc=[15:0].
- Operand 2 is GPR[rsrc2] when mode=0, or isrc zero-extended to DATA_W when mode=1.
- Opcodes:
  - 0 movsgpr: rdst<=SGPR
  - 1 mov: rdst<=op2
  - 2 add
  - 3 sub
  - 4 mul
  - 5 or
  - 6 and
  - 7 xor
  - 8 xnor
  - 9 nand
  - 10 nor
  - 11 not: rdst<=~op1
  - 12..31 illegal.
- An instruction is also illegal if rdst, rsrc1, or (mode=0) rsrc2 is >= NUM_GPR.
- FSM states are IDLE, EXEC, MUL, WB; instr_ready=1 only in IDLE.
  - IDLE: if instr_valid at edge T, latch IR and go to EXEC.
  - EXEC (cycle T+1): read operands and register the result. Go to MUL for a legal mul when the macro is defined; otherwise go to WB.
  - MUL: iterative shift-add, DATA_W cycles, then WB.
  - WB: done=1; wb_addr=rdst; wb_data=result. At the closing edge the GPR is written (legal ops only) and flags are updated; return to IDLE.
- Latency: non-mul done in cycle T+2, GPR visible on dbg_data in cycle T+3. Throughput is one instruction per 3 cycles.
- add: carry = bit DATA_W of the (DATA_W+1)-bit sum; overflow = signed overflow.
- sub: op1-op2; carry = borrow (op1<op2, unsigned); overflow = signed overflow.
- Flag updates:
  - All legal ops update zero (result==0) and sign (result[DATA_W-1]).
  - Ops other than add/sub clear carry and overflow.
  - Illegal ops leave flags, GPRs, and SGPR unchanged; err=1 and wb_data=0.
- Results are truncated to DATA_W bits.
- instr_valid outside IDLE is ignored and the instruction is not captured; the producer holds it until ready.
- Reset (async assert, any state): state=IDLE.
  - All GPRs, SGPR, IR, flags, wb_data, and wb_addr are cleared to 0.
  - done=0, err=0; instr_ready=1 once reset is released.
  - An in-flight instruction is discarded with no writeback.

Optional Feature:
- IR_ALU_MUL_EN.
- Defined: opcode 4 is legal. The 2*DATA_W unsigned product is computed over DATA_W MUL cycles, so done arrives in cycle T+2+DATA_W. rdst<=low word, SGPR<=high word, zero/sign taken from the low word.
- Undefined: no MUL state and no multiplier logic. Opcode 4 is illegal and retires in cycle T+2 with err=1.

Test Plan:
- Reset, all GPRs preloaded to 2; add, mode=1, rsrc1=2, isrc=4, rdst=0 → done at T+2, wb_data=6, GPR[0]=6, flags=0000.
- sub, mode=0, GPR[1]=3, GPR[2]=5, rdst=3 → GPR[3]=0xFFFFFFFE, sign=1, carry=1, zero=0, overflow=0.
- add 0x7FFFFFFF+1 (mode=1) → result 0x80000000, overflow=1, sign=1. Then an or → carry and overflow cleared.
- With IR_ALU_MUL_EN: GPR[1]=0xFFFFFFFF times isrc=2 → done at T+34, GPR[rdst]=0xFFFFFFFE, sgpr=1. A following movsgpr to rdst=5 → GPR[5]=1. Without the macro the same mul → err=1 at T+2, GPR unchanged.
- Opcode 15, and separately NUM_GPR=8 with rdst=9 → err pulse, no GPR change, flags unchanged.
- Assert sys_rst_n low during EXEC of an add → no done pulse, GPRs read 0, instr_ready=1 after release. Holding instr_valid during WB → the instruction is accepted only in the following IDLE cycle.
